io_port_responder: RTL and testbench

Far-end responder for the CPU's memory-mapped I/O ports. For each of `IO_PORT_COUNT` ports it buffers host-to-CPU words, which the CPU drains through `io_read_EF`, `io_rden` and `io_read_data`. It also buffers CPU-to-host words, which the CPU fills through `io_write_EF`, `io_wren` and `io_write_data`. It sits beside the CPU in test benches and system tops and connects one port bank (A or B) to host-side valid/ready streams.

---
 rtl/io_port_responder_pkg.sv | 9 +
 rtl/io_port_fifo.sv | 71 +++++++
 rtl/io_port_responder.sv | 93 +++++++++
 tb/tb_io_port_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_responder_pkg.sv
// Shared defaults for the I/O port responder: word width and per-port FIFO geometry.
package io_port_responder_pkg;

  localparam int DEFAULT_WORD_WIDTH      = 36;
  localparam int DEFAULT_IO_PORT_COUNT   = 8;
  localparam int DEFAULT_FIFO_DEPTH      = 4;
  localparam int DEFAULT_FIFO_ADDR_WIDTH = 2;

endpackage

// File: rtl/io_port_fifo.sv
// Show-ahead synchronous FIFO with zero-forced head when empty and a one-cycle
// error pulse on a push while full and/or a pop while empty.
module io_port_fifo
  import io_port_responder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WORD_WIDTH,
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int AW         = DEFAULT_FIFO_ADDR_WIDTH,
  parameter bit CHECK_PUSH = 1'b1,
  parameter bit CHECK_POP  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, empty;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  // Acceptance uses only registered state, so a pop never frees a slot for a
  // push in the same cycle and a push never feeds a pop in the same cycle.
  assign push_ok = push_i & ~full;
  assign pop_ok  = pop_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale words are hidden by the empty masking below.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign full_o  = full;
  assign empty_o = empty;
  assign err_o   = (CHECK_PUSH & push_i & full) | (CHECK_POP & pop_i & empty);

endmodule

// File: rtl/io_port_responder.sv
// Far-end responder for one CPU I/O port bank: per port, a host->CPU read FIFO
// and a CPU->host write FIFO, plus sticky underflow/overflow flags.
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter int WORD_WIDTH      = DEFAULT_WORD_WIDTH,
  parameter int IO_PORT_COUNT   = DEFAULT_IO_PORT_COUNT,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [IO_PORT_COUNT-1:0]            io_rden,
  output logic [IO_PORT_COUNT-1:0]            io_read_EF,
  output logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_read_data,
  input  logic [IO_PORT_COUNT-1:0]            io_wren,
  input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
  output logic [IO_PORT_COUNT-1:0]            io_write_EF,
  input  logic [IO_PORT_COUNT-1:0]            host_push_valid,
  output logic [IO_PORT_COUNT-1:0]            host_push_ready,
  input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] host_push_data,
  output logic [IO_PORT_COUNT-1:0]            host_pop_valid,
  input  logic [IO_PORT_COUNT-1:0]            host_pop_ready,
  output logic [IO_PORT_COUNT*WORD_WIDTH-1:0] host_pop_data,
  output logic [IO_PORT_COUNT-1:0]            underflow,
  output logic [IO_PORT_COUNT-1:0]            overflow
);

  if (FIFO_DEPTH != (1 << FIFO_ADDR_WIDTH) || FIFO_DEPTH < 2) begin : g_bad_depth
    $error("io_port_responder: FIFO_DEPTH must equal 2**FIFO_ADDR_WIDTH and be >= 2");
  end

  logic [IO_PORT_COUNT-1:0] rd_full, rd_empty, rd_err;
  logic [IO_PORT_COUNT-1:0] wr_full, wr_empty, wr_err;
  logic [IO_PORT_COUNT-1:0] underflow_q, underflow_d;
  logic [IO_PORT_COUNT-1:0] overflow_q, overflow_d;

  // Host streams use valid/ready: a word transfers on a cycle where both are
  // high; ready/valid depend only on registered FIFO state, never on inputs.
  for (genvar i = 0; i < IO_PORT_COUNT; i++) begin : g_port
    io_port_fifo #(
      .WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH), .AW(FIFO_ADDR_WIDTH),
      .CHECK_PUSH(1'b0), .CHECK_POP(1'b1)
    ) u_read_fifo (
      .clk_i      (clock),
      .rst_i      (reset),
      .push_i     (host_push_valid[i]),
      .push_data_i(host_push_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .pop_i      (io_rden[i]),
      .head_o     (io_read_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .full_o     (rd_full[i]),
      .empty_o    (rd_empty[i]),
      .err_o      (rd_err[i])
    );

    io_port_fifo #(
      .WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH), .AW(FIFO_ADDR_WIDTH),
      .CHECK_PUSH(1'b1), .CHECK_POP(1'b0)
    ) u_write_fifo (
      .clk_i      (clock),
      .rst_i      (reset),
      .push_i     (io_wren[i]),
      .push_data_i(io_write_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .pop_i      (host_pop_ready[i]),
      .head_o     (host_pop_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .full_o     (wr_full[i]),
      .empty_o    (wr_empty[i]),
      .err_o      (wr_err[i])
    );
  end

  assign host_push_ready = ~rd_full;
  assign io_read_EF      = ~rd_empty;
  assign io_write_EF     = ~wr_full;
  assign host_pop_valid  = ~wr_empty;

  assign underflow_d = underflow_q | rd_err;
  assign overflow_d  = overflow_q | wr_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_q <= '0;
      overflow_q  <= '0;
    end else begin
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign underflow = underflow_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: reset values, read/write paths,
// overflow/underflow, full+pop, and reset with words in flight.
module tb_io_port_responder;

  localparam int W = 36;
  localparam int N = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   io_rden, io_read_EF, io_wren, io_write_EF;
  logic [N*W-1:0] io_read_data, io_write_data, host_push_data, host_pop_data;
  logic [N-1:0]   host_push_valid, host_push_ready, host_pop_valid, host_pop_ready;
  logic [N-1:0]   underflow, overflow;

  int checks   = 0;
  int failures = 0;

  io_port_responder dut (
    .clock          (clock),
    .reset          (reset),
    .io_rden        (io_rden),
    .io_read_EF     (io_read_EF),
    .io_read_data   (io_read_data),
    .io_wren        (io_wren),
    .io_write_data  (io_write_data),
    .io_write_EF    (io_write_EF),
    .host_push_valid(host_push_valid),
    .host_push_ready(host_push_ready),
    .host_push_data (host_push_data),
    .host_pop_valid (host_pop_valid),
    .host_pop_ready (host_pop_ready),
    .host_pop_data  (host_pop_data),
    .underflow      (underflow),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  // One rising edge; outputs are sampled 1 time unit afterwards.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_rden         = '0;
    io_wren         = '0;
    io_write_data   = '0;
    host_push_valid = '0;
    host_push_data  = '0;
    host_pop_ready  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if (io_read_EF !== 8'h00) begin failures++; $display("FAIL reset_read_EF got=%h exp=00", io_read_EF); end
    checks++;
    if (io_write_EF !== 8'hFF) begin failures++; $display("FAIL reset_write_EF got=%h exp=ff", io_write_EF); end
    checks++;
    if (host_push_ready !== 8'hFF) begin failures++; $display("FAIL reset_push_ready got=%h exp=ff", host_push_ready); end
    checks++;
    if (host_pop_valid !== 8'h00) begin failures++; $display("FAIL reset_pop_valid got=%h exp=00", host_pop_valid); end
    checks++;
    if (io_read_data !== '0 || host_pop_data !== '0) begin
      failures++; $display("FAIL reset_data read=%h pop=%h exp=0", io_read_data, host_pop_data);
    end
    checks++;
    if (underflow !== 8'h00 || overflow !== 8'h00) begin
      failures++; $display("FAIL reset_flags uf=%h of=%h exp=00", underflow, overflow);
    end
  endtask

  task automatic test_read_path();
    host_push_valid[3] = 1'b1;
    host_push_data[3*W +: W] = 36'h123456789;
    cyc();
    checks++;
    if (io_read_EF[3] !== 1'b1 || io_read_data[3*W +: W] !== 36'h123456789) begin
      failures++; $display("FAIL rd_first ef=%b data=%h exp ef=1 data=123456789", io_read_EF[3], io_read_data[3*W +: W]);
    end
    host_push_data[3*W +: W] = 36'hABCDEF012;
    cyc();
    host_push_valid[3] = 1'b0;
    host_push_data = '0;
    checks++;
    if (io_read_data[3*W +: W] !== 36'h123456789) begin
      failures++; $display("FAIL rd_head_hold data=%h exp=123456789", io_read_data[3*W +: W]);
    end
    io_rden[3] = 1'b1;
    cyc();
    checks++;
    if (io_read_EF[3] !== 1'b1 || io_read_data[3*W +: W] !== 36'hABCDEF012) begin
      failures++; $display("FAIL rd_second ef=%b data=%h exp ef=1 data=abcdef012", io_read_EF[3], io_read_data[3*W +: W]);
    end
    cyc();
    io_rden[3] = 1'b0;
    checks++;
    if (io_read_EF[3] !== 1'b0 || io_read_data[3*W +: W] !== '0) begin
      failures++; $display("FAIL rd_drained ef=%b data=%h exp ef=0 data=0", io_read_EF[3], io_read_data[3*W +: W]);
    end
    checks++;
    if (underflow !== 8'h00) begin failures++; $display("FAIL rd_no_underflow got=%h exp=00", underflow); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      io_wren[5] = 1'b1;
      io_write_data[5*W +: W] = 36'(k);
      cyc();
      if (k == 1) begin
        checks++;
        if (host_pop_valid[5] !== 1'b1 || host_pop_data[5*W +: W] !== 36'd1) begin
          failures++; $display("FAIL wr_first valid=%b data=%h exp valid=1 data=1", host_pop_valid[5], host_pop_data[5*W +: W]);
        end
      end
      if (k == 3) begin
        checks++;
        if (io_write_EF[5] !== 1'b1) begin failures++; $display("FAIL wr_ef_3 got=%b exp=1", io_write_EF[5]); end
      end
      if (k == 4) begin
        checks++;
        if (io_write_EF[5] !== 1'b0 || overflow !== 8'h00) begin
          failures++; $display("FAIL wr_full ef=%b of=%h exp ef=0 of=00", io_write_EF[5], overflow);
        end
      end
    end
    io_wren = '0;
    io_write_data = '0;
    checks++;
    if (overflow !== 8'h20) begin failures++; $display("FAIL wr_overflow got=%h exp=20", overflow); end
    host_pop_ready[5] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (host_pop_valid[5] !== 1'b1 || host_pop_data[5*W +: W] !== 36'(k)) begin
        failures++; $display("FAIL wr_pop_%0d valid=%b data=%h exp valid=1 data=%0d", k, host_pop_valid[5], host_pop_data[5*W +: W], k);
      end
      cyc();
    end
    host_pop_ready[5] = 1'b0;
    checks++;
    if (host_pop_valid[5] !== 1'b0 || host_pop_data[5*W +: W] !== '0 || io_write_EF[5] !== 1'b1) begin
      failures++; $display("FAIL wr_empty valid=%b data=%h ef=%b exp 0/0/1", host_pop_valid[5], host_pop_data[5*W +: W], io_write_EF[5]);
    end
  endtask

  task automatic test_underflow();
    io_rden[0] = 1'b1;
    host_push_valid[0] = 1'b1;
    host_push_data[0 +: W] = 36'd7;
    cyc();
    idle_inputs();
    checks++;
    if (underflow !== 8'h01) begin failures++; $display("FAIL uf_flag got=%h exp=01", underflow); end
    checks++;
    if (io_read_EF[0] !== 1'b1 || io_read_data[0 +: W] !== 36'd7) begin
      failures++; $display("FAIL uf_push_kept ef=%b data=%h exp ef=1 data=7", io_read_EF[0], io_read_data[0 +: W]);
    end
    io_rden[0] = 1'b1;
    cyc();
    io_rden[0] = 1'b0;
    checks++;
    if (io_read_EF[0] !== 1'b0 || underflow !== 8'h01) begin
      failures++; $display("FAIL uf_drain ef=%b uf=%h exp ef=0 uf=01", io_read_EF[0], underflow);
    end
  endtask

  task automatic test_full_pop();
    host_push_valid[2] = 1'b1;
    for (int k = 10; k <= 13; k++) begin
      host_push_data[2*W +: W] = 36'(k);
      cyc();
    end
    checks++;
    if (host_push_ready[2] !== 1'b0 || io_read_data[2*W +: W] !== 36'd10) begin
      failures++; $display("FAIL fp_full ready=%b head=%h exp ready=0 head=a", host_push_ready[2], io_read_data[2*W +: W]);
    end
    io_rden[2] = 1'b1;
    host_push_data[2*W +: W] = 36'd9;
    cyc();
    idle_inputs();
    checks++;
    if (host_push_ready[2] !== 1'b1 || io_read_data[2*W +: W] !== 36'd11) begin
      failures++; $display("FAIL fp_after ready=%b head=%h exp ready=1 head=b", host_push_ready[2], io_read_data[2*W +: W]);
    end
    io_rden[2] = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      checks++;
      if (io_read_EF[2] !== 1'b1 || io_read_data[2*W +: W] !== 36'(k)) begin
        failures++; $display("FAIL fp_drain_%0d ef=%b data=%h exp ef=1 data=%0d", k, io_read_EF[2], io_read_data[2*W +: W], k);
      end
      cyc();
    end
    io_rden[2] = 1'b0;
    checks++;
    if (io_read_EF[2] !== 1'b0 || underflow !== 8'h01) begin
      failures++; $display("FAIL fp_empty ef=%b uf=%h exp ef=0 uf=01 (9 must have been refused)", io_read_EF[2], underflow);
    end
  endtask

  task automatic test_reset_mid();
    host_push_valid[6] = 1'b1;
    io_wren[6] = 1'b1;
    host_push_data[6*W +: W] = 36'd20;
    io_write_data[6*W +: W]  = 36'd30;
    cyc();
    host_push_data[6*W +: W] = 36'd21;
    io_write_data[6*W +: W]  = 36'd31;
    cyc();
    idle_inputs();
    checks++;
    if (io_read_EF[6] !== 1'b1 || host_pop_valid[6] !== 1'b1) begin
      failures++; $display("FAIL rm_loaded ef=%b valid=%b exp 1/1", io_read_EF[6], host_pop_valid[6]);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (io_read_EF !== 8'h00 || host_pop_valid !== 8'h00 || io_write_EF !== 8'hFF || host_push_ready !== 8'hFF) begin
      failures++; $display("FAIL rm_status ef=%h valid=%h wef=%h rdy=%h exp 00/00/ff/ff", io_read_EF, host_pop_valid, io_write_EF, host_push_ready);
    end
    checks++;
    if (io_read_data !== '0 || host_pop_data !== '0 || underflow !== 8'h00 || overflow !== 8'h00) begin
      failures++; $display("FAIL rm_clear read=%h pop=%h uf=%h of=%h exp all 0", io_read_data, host_pop_data, underflow, overflow);
    end
    host_push_valid[6] = 1'b1;
    io_wren[6] = 1'b1;
    host_push_data[6*W +: W] = 36'd40;
    io_write_data[6*W +: W]  = 36'd50;
    cyc();
    idle_inputs();
    checks++;
    if (io_read_data[6*W +: W] !== 36'd40 || host_pop_data[6*W +: W] !== 36'd50) begin
      failures++; $display("FAIL rm_roundtrip read=%h pop=%h exp 28/32", io_read_data[6*W +: W], host_pop_data[6*W +: W]);
    end
    io_rden[6] = 1'b1;
    host_pop_ready[6] = 1'b1;
    cyc();
    idle_inputs();
    checks++;
    if (io_read_EF[6] !== 1'b0 || host_pop_valid[6] !== 1'b0) begin
      failures++; $display("FAIL rm_drained ef=%b valid=%b exp 0/0", io_read_EF[6], host_pop_valid[6]);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_read_path();
    test_overflow();
    test_underflow();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
